// File: rtl/tp_input_monitor.sv
// rtl/tp_input_monitor.sv - testpoint debouncer, rising-edge counters, snapshot shadows; optional injection via TP_INJECT_EN
module tp_input_monitor #(
    parameter int DEB_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST_B,
    input  logic [3:0]       TP_IN,
    output logic [3:0]       TP_LVL,
    output logic [3:0]       TP_PULSE,
    input  logic             CNT_CLR,
    input  logic             SNAP_REQ,
    output logic             SNAP_ACK,
    input  logic [1:0]       RD_SEL,
    output logic [CNT_W-1:0] RD_DATA,
    input  logic             INJ_ENA,
    output logic             INJ_L1A,
    output logic             INJ_LCT
);

    localparam logic [3:0] DEB_MAX = 4'(DEB_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        ACK  = 2'd2
    } snap_state_e;

    logic [3:0]            sync1_q, sync2_q;
    logic [3:0]            lvl_q, lvl_d;
    logic [3:0]            pulse_q, pulse_d;
    logic [3:0][3:0]       stab_q, stab_d;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0][CNT_W-1:0] shadow_q, shadow_d;
    snap_state_e           state_q, state_d;

    // A channel only flips after its synchronized value has differed for DEB_LEN cycles in a row.
    always_comb begin
        lvl_d   = lvl_q;
        pulse_d = '0;
        stab_d  = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                if (stab_q[i] == DEB_MAX) begin
                    lvl_d[i]   = ~lvl_q[i];
                    pulse_d[i] = ~lvl_q[i];
                end else begin
                    stab_d[i] = stab_q[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (CNT_CLR) begin
                cnt_d[i] = '0;
            end else if (pulse_q[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Shadows take the live counters as they stand before this cycle's increment or clear.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (SNAP_REQ) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                shadow_d = cnt_q;
                state_d  = ACK;
            end
            ACK: begin
                if (!SNAP_REQ) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            pulse_q  <= '0;
            stab_q   <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            state_q  <= IDLE;
        end else begin
            sync1_q  <= TP_IN;
            sync2_q  <= sync1_q;
            lvl_q    <= lvl_d;
            pulse_q  <= pulse_d;
            stab_q   <= stab_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            state_q  <= state_d;
        end
    end

    assign TP_LVL   = lvl_q;
    assign TP_PULSE = pulse_q;
    assign SNAP_ACK = (state_q == ACK);
    assign RD_DATA  = shadow_q[RD_SEL];

`ifdef TP_INJECT_EN
    logic inj_l1a_q, inj_lct_q;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            inj_l1a_q <= 1'b0;
            inj_lct_q <= 1'b0;
        end else begin
            inj_l1a_q <= pulse_q[0] & INJ_ENA;
            inj_lct_q <= pulse_q[1] & INJ_ENA;
        end
    end

    assign INJ_L1A = inj_l1a_q;
    assign INJ_LCT = inj_lct_q;
`else
    logic unused_inj_ena;

    assign unused_inj_ena = INJ_ENA;
    assign INJ_L1A        = 1'b0;
    assign INJ_LCT        = 1'b0;
`endif

endmodule

// File: tb/tb_tp_input_monitor.sv
// tb/tb_tp_input_monitor.sv - scoreboard bench for tp_input_monitor
module tb_tp_input_monitor;

    logic        CLK;
    logic        RST_B;
    logic [3:0]  TP_IN;
    logic [3:0]  TP_LVL, TP_PULSE;
    logic        CNT_CLR, SNAP_REQ, SNAP_ACK;
    logic [1:0]  RD_SEL;
    logic [15:0] RD_DATA;
    logic        INJ_ENA, INJ_L1A, INJ_LCT;

    logic [3:0]  s_lvl, s_pulse;
    logic        s_ack, s_l1a, s_lct;
    logic [1:0]  s_rd;

    int checks;
    int failures;

    logic [3:0] exp_pulse_q[$];
    logic [3:0] prev_pulse;
    logic       prev_ena;

    tp_input_monitor #(.DEB_LEN(4), .CNT_W(16)) u_dut (
        .CLK(CLK), .RST_B(RST_B), .TP_IN(TP_IN), .TP_LVL(TP_LVL), .TP_PULSE(TP_PULSE),
        .CNT_CLR(CNT_CLR), .SNAP_REQ(SNAP_REQ), .SNAP_ACK(SNAP_ACK), .RD_SEL(RD_SEL),
        .RD_DATA(RD_DATA), .INJ_ENA(INJ_ENA), .INJ_L1A(INJ_L1A), .INJ_LCT(INJ_LCT)
    );

    // Narrow-counter copy: all-ones is 3, so five edges show saturation instead of wrap.
    tp_input_monitor #(.DEB_LEN(4), .CNT_W(2)) u_sat (
        .CLK(CLK), .RST_B(RST_B), .TP_IN(TP_IN), .TP_LVL(s_lvl), .TP_PULSE(s_pulse),
        .CNT_CLR(CNT_CLR), .SNAP_REQ(SNAP_REQ), .SNAP_ACK(s_ack), .RD_SEL(RD_SEL),
        .RD_DATA(s_rd), .INJ_ENA(INJ_ENA), .INJ_L1A(s_l1a), .INJ_LCT(s_lct)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every pulse seen must match the next expected pulse; injection follows the pulse model.
    always @(negedge CLK) begin
        logic [1:0] exp_inj;
        exp_inj = 2'b00;
`ifdef TP_INJECT_EN
        if (RST_B) exp_inj = prev_pulse[1:0] & {2{prev_ena}};
`endif
        check("inj_outputs", {30'd0, INJ_LCT, INJ_L1A}, {30'd0, exp_inj});
        if (RST_B && TP_PULSE != 4'd0) begin
            if (exp_pulse_q.size() == 0) begin
                check("unexpected_pulse", {28'd0, TP_PULSE}, 32'd0);
            end else begin
                check("pulse_channel", {28'd0, TP_PULSE}, {28'd0, exp_pulse_q.pop_front()});
            end
        end
        prev_pulse = RST_B ? TP_PULSE : 4'd0;
        prev_ena   = INJ_ENA;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic edge_on(input int ch, input int hi);
        exp_pulse_q.push_back(4'b0001 << ch);
        TP_IN[ch] = 1'b1;
        cyc(hi);
        TP_IN[ch] = 1'b0;
        cyc(8);
    endtask

    task automatic wait_ack(input string nm);
        int n;
        n = 0;
        while (!SNAP_ACK && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check(nm, {31'd0, SNAP_ACK}, 32'd1);
    endtask

    task automatic rd(input string nm, input logic [1:0] sel, input logic [15:0] exp);
        RD_SEL = sel;
        #1;
        check(nm, {16'd0, RD_DATA}, {16'd0, exp});
    endtask

    initial begin
        checks = 0;
        failures = 0;
        prev_pulse = 4'd0;
        prev_ena = 1'b0;
        RST_B = 1'b0;
        TP_IN = 4'd0;
        CNT_CLR = 1'b0;
        SNAP_REQ = 1'b0;
        RD_SEL = 2'd0;
        INJ_ENA = 1'b1;
        cyc(3);
        check("rst_lvl", {28'd0, TP_LVL}, 32'd0);
        check("rst_pulse", {28'd0, TP_PULSE}, 32'd0);
        check("rst_ack", {31'd0, SNAP_ACK}, 32'd0);
        for (int i = 0; i < 4; i++) rd("rst_shadow", 2'(i), 16'd0);
        RST_B = 1'b1;
        cyc(3);

        // Debounce latency on channel 0: level rises after edge k+5.
        exp_pulse_q.push_back(4'b0001);
        TP_IN[0] = 1'b1;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check("lat_lvl0_k4", {31'd0, TP_LVL[0]}, 32'd0);
        @(negedge CLK);
        check("lat_lvl0_k5", {31'd0, TP_LVL[0]}, 32'd1);
        check("lat_pulse0", {31'd0, TP_PULSE[0]}, 32'd1);
        cyc(4);
        TP_IN[0] = 1'b0;
        cyc(12);
        check("fall_lvl0", {31'd0, TP_LVL[0]}, 32'd0);
        INJ_ENA = 1'b0;

        // Channel 1: a 3-cycle glitch is rejected, exactly 4 cycles is accepted.
        TP_IN[1] = 1'b1;
        cyc(3);
        TP_IN[1] = 1'b0;
        cyc(10);
        check("glitch_lvl1", {31'd0, TP_LVL[1]}, 32'd0);
        edge_on(1, 4);
        cyc(4);

        for (int i = 0; i < 5; i++) edge_on(2, 8);
        for (int i = 0; i < 5; i++) edge_on(3, 8);

        // Sixth channel-3 edge: capture cycle coincides with the 5->6 increment and a clear.
        exp_pulse_q.push_back(4'b1000);
        TP_IN[3] = 1'b1;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        SNAP_REQ = 1'b1;
        @(negedge CLK);
        check("capt_pulse3", {31'd0, TP_PULSE[3]}, 32'd1);
        CNT_CLR = 1'b1;
        @(negedge CLK);
        CNT_CLR = 1'b0;
        TP_IN[3] = 1'b0;
        check("capt_ack", {31'd0, SNAP_ACK}, 32'd1);
        rd("shadow0", 2'd0, 16'd1);
        rd("shadow1", 2'd1, 16'd1);
        rd("shadow2", 2'd2, 16'd5);
        rd("shadow3", 2'd3, 16'd5);
        RD_SEL = 2'd2;
        #1;
        check("sat_shadow2", {30'd0, s_rd}, 32'd3);
        cyc(3);
        check("ack_held", {31'd0, SNAP_ACK}, 32'd1);
        SNAP_REQ = 1'b0;
        cyc(1);
        check("ack_drop", {31'd0, SNAP_ACK}, 32'd0);
        cyc(2);
        SNAP_REQ = 1'b1;
        wait_ack("ack_after_clr");
        SNAP_REQ = 1'b0;
        for (int i = 0; i < 4; i++) rd("cleared_shadow", 2'(i), 16'd0);
        cyc(12);

        // Reset in ACK, with channel 0 high through the release.
        SNAP_REQ = 1'b1;
        wait_ack("ack_before_rst");
        TP_IN[0] = 1'b1;
        exp_pulse_q.push_back(4'b0001);
        #2;
        RST_B = 1'b0;
        #1;
        check("rst_async_ack", {31'd0, SNAP_ACK}, 32'd0);
        check("rst_async_lvl", {28'd0, TP_LVL}, 32'd0);
        SNAP_REQ = 1'b0;
        cyc(3);
        RST_B = 1'b1;
        SNAP_REQ = 1'b1;
        wait_ack("ack_after_rst");
        SNAP_REQ = 1'b0;
        for (int i = 0; i < 4; i++) rd("post_rst_count", 2'(i), 16'd0);
        cyc(15);
        check("rst_high_lvl0", {31'd0, TP_LVL[0]}, 32'd1);
        TP_IN[0] = 1'b0;
        cyc(12);
        check("pulses_outstanding", exp_pulse_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
